bayer_stream_gen: RTL and testbench

Synthetic camera-side source for the Bayer capture path. It produces the same 12-bit raw stream that the sensor front end delivers: pixel data, data-valid, and column/row counters. This lets the grayscale/Sobel pipeline and the downstream SDRAM/VGA path run without a sensor. Every pattern is constant across each aligned 2x2 Bayer cell, so the 2x2 grayscale average equals the generated level exactly and edge outputs are predictable.

---
 rtl/bayer_gen_pkg.sv | 33 +++
 rtl/bayer_stream_gen_if.sv | 13 +
 rtl/bayer_pattern_calc.sv | 32 +++
 rtl/bayer_stream_gen.sv | 182 ++++++++++++++++++
 tb/tb_bayer_stream_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bayer_gen_pkg.sv
// Shared types and constants for the synthetic Bayer stream source.
package bayer_gen_pkg;

   localparam int unsigned PIX_W   = 12;
   localparam int unsigned COORD_W = 11;
   localparam int unsigned MODE_W  = 2;
   localparam int unsigned FCNT_W  = 16;

   typedef logic [PIX_W-1:0]   pix_t;
   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [MODE_W-1:0]  mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HBLANK = 2'd2,
      VBLANK = 2'd3
   } state_e;

   localparam mode_t MODE_FLAT  = 2'd0;
   localparam mode_t MODE_RAMP  = 2'd1;
   localparam mode_t MODE_BAR   = 2'd2;
   localparam mode_t MODE_CHECK = 2'd3;

   // One output beat of the raw stream: value, valid and coordinates.
   typedef struct packed {
      pix_t   data;
      logic   dval;
      coord_t x;
      coord_t y;
   } pix_beat_t;

endpackage

// File: rtl/bayer_stream_gen_if.sv
// Raw pixel stream as delivered by the sensor front end.
interface bayer_stream_gen_if;
   import bayer_gen_pkg::*;

   pix_t   oDATA;
   logic   oDVAL;
   coord_t oX_Cont;
   coord_t oY_Cont;

   modport master (output oDATA, output oDVAL, output oX_Cont, output oY_Cont);
   modport slave  (input  oDATA, input  oDVAL, input  oX_Cont, input  oY_Cont);

endinterface

// File: rtl/bayer_pattern_calc.sv
// Combinational test-pattern value for one pixel; constant over each 2x2 cell.
module bayer_pattern_calc
   import bayer_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640
) (
   input  mode_t  mode,
   input  pix_t   level,
   input  coord_t x,
   input  coord_t y,
   output pix_t   pix_c
);

   localparam coord_t X_HALF = COORD_W'(H_ACTIVE / 2);

   // Only bit 4 of the row takes part in the checker pattern.
   logic unused_y;
   assign unused_y = ^{y[COORD_W-1:5], y[3:0]};

   // Pattern select; ramp drops x[0] so both columns of a cell match.
   always_comb begin
      pix_c = '0;
      case (mode)
         MODE_FLAT:  pix_c = level;
         MODE_RAMP:  pix_c = {x[COORD_W-1:1], 2'b00};
         MODE_BAR:   pix_c = (x < X_HALF) ? '0 : level;
         MODE_CHECK: pix_c = (x[4] ^ y[4]) ? level : '0;
         default:    pix_c = '0;
      endcase
   end

endmodule

// File: rtl/bayer_stream_gen.sv
// Synthetic Bayer raw-stream source: frame timing FSM, counters, registered outputs.
module bayer_stream_gen
   import bayer_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned H_BLANK  = 160,
   parameter int unsigned V_BLANK  = 45
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iPIX_EN,
   input  logic               iSTART,
   input  logic               iCONT,
   input  mode_t              iMODE,
   input  pix_t               iLEVEL,
   bayer_stream_gen_if.master pix,
   output logic               oBUSY,
   output logic               oDONE,
   output logic [FCNT_W-1:0]  oFRAME_CNT
);

   localparam int unsigned LINE_SLOTS = H_ACTIVE + H_BLANK;
   localparam int unsigned VB_SLOTS   = V_BLANK * LINE_SLOTS;
   localparam int unsigned CNT_MAX    = (VB_SLOTS > H_BLANK) ? VB_SLOTS : H_BLANK;
   localparam int unsigned CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] HB_LAST = CNT_W'((H_BLANK == 0) ? 0 : H_BLANK - 1);
   localparam logic [CNT_W-1:0] VB_LAST = CNT_W'((VB_SLOTS == 0) ? 0 : VB_SLOTS - 1);
   localparam coord_t           X_LAST  = COORD_W'(H_ACTIVE - 1);
   localparam coord_t           Y_LAST  = COORD_W'(V_ACTIVE - 1);

   state_e              state_q, state_d;
   coord_t              x_q, x_d;
   coord_t              y_q, y_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   mode_t               mode_q, mode_d;
   pix_t                level_q, level_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   pix_beat_t           beat_q, beat_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                line_end;
   logic                frame_end;
   pix_t                pix_c;

   bayer_pattern_calc #(
      .H_ACTIVE (H_ACTIVE)
   ) u_calc (
      .mode  (mode_q),
      .level (level_q),
      .x     (x_q),
      .y     (y_q),
      .pix_c (pix_c)
   );

   // State register.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, counters and output beat; nothing moves without iPIX_EN.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      level_d   = level_q;
      fcnt_d    = fcnt_q;
      beat_d    = beat_q;
      beat_d.dval = 1'b0;
      done_d    = 1'b0;
      line_end  = 1'b0;
      frame_end = 1'b0;

      if (iPIX_EN) begin
         case (state_q)
            IDLE: begin
               if (iSTART) begin
                  mode_d  = iMODE;
                  level_d = iLEVEL;
                  x_d     = '0;
                  y_d     = '0;
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               beat_d.data = pix_c;
               beat_d.dval = 1'b1;
               beat_d.x    = x_q;
               beat_d.y    = y_q;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (H_BLANK == 0) begin
                     line_end = 1'b1;
                  end else begin
                     cnt_d   = '0;
                     state_d = HBLANK;
                  end
               end else begin
                  x_d = x_q + COORD_W'(1);
               end
            end
            HBLANK: begin
               if (cnt_q == HB_LAST) line_end = 1'b1;
               else                  cnt_d    = cnt_q + CNT_W'(1);
            end
            VBLANK: begin
               if (cnt_q == VB_LAST) frame_end = 1'b1;
               else                  cnt_d     = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
         endcase

         // End of a line: next row, or vertical blanking / frame end after the last row.
         if (line_end) begin
            if (y_q != Y_LAST) begin
               y_d     = y_q + COORD_W'(1);
               state_d = ACTIVE;
            end else if (VB_SLOTS == 0) begin
               frame_end = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = VBLANK;
            end
         end

         // End of frame: pulse, count, then restart immediately or go idle.
         if (frame_end) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + FCNT_W'(1);
            if (iCONT) begin
               mode_d  = iMODE;
               level_d = iLEVEL;
               x_d     = '0;
               y_d     = '0;
               state_d = ACTIVE;
            end else begin
               state_d = IDLE;
            end
         end
      end

      busy_d = (state_d != IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         level_q <= '0;
         fcnt_q  <= '0;
         beat_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         level_q <= level_d;
         fcnt_q  <= fcnt_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pix.oDATA   = beat_q.data;
   assign pix.oDVAL   = beat_q.dval;
   assign pix.oX_Cont = beat_q.x;
   assign pix.oY_Cont = beat_q.y;
   assign oBUSY       = busy_q;
   assign oDONE       = done_q;
   assign oFRAME_CNT  = fcnt_q;

endmodule

// File: tb/tb_bayer_stream_gen.sv
// Bench for bayer_stream_gen: two geometries against a slot-indexed frame model.
module tb_bayer_stream_gen;

   localparam int HA = 8,  VA = 4,  HB = 2, VB = 1;
   localparam int HA2 = 40, VA2 = 20, HB2 = 2, VB2 = 0;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iPIX_EN = 1'b0;
   logic        iSTART = 1'b0;
   logic        iCONT = 1'b0;
   logic [1:0]  iMODE = 2'd0;
   logic [11:0] iLEVEL = 12'd0;

   logic        a_busy, a_done, b_busy, b_done;
   logic [15:0] a_fcnt, b_fcnt;

   bayer_stream_gen_if bus_a();
   bayer_stream_gen_if bus_b();

   bayer_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut_a (
      .iCLK(iCLK), .iRST(iRST), .iPIX_EN(iPIX_EN), .iSTART(iSTART), .iCONT(iCONT),
      .iMODE(iMODE), .iLEVEL(iLEVEL), .pix(bus_a),
      .oBUSY(a_busy), .oDONE(a_done), .oFRAME_CNT(a_fcnt));

   bayer_stream_gen #(.H_ACTIVE(HA2), .V_ACTIVE(VA2), .H_BLANK(HB2), .V_BLANK(VB2)) dut_b (
      .iCLK(iCLK), .iRST(iRST), .iPIX_EN(iPIX_EN), .iSTART(iSTART), .iCONT(iCONT),
      .iMODE(iMODE), .iLEVEL(iLEVEL), .pix(bus_b),
      .oBUSY(b_busy), .oDONE(b_done), .oFRAME_CNT(b_fcnt));

   always #5 iCLK = ~iCLK;

   // Reference: a running frame is just a slot index; pixel/blank/done follow from it.
   typedef struct {
      bit          run;
      int          slot;
      logic [1:0]  mode;
      logic [11:0] level;
      logic [15:0] frames;
      logic [11:0] data;
      logic [10:0] x;
      logic [10:0] y;
      bit          dval;
      bit          done;
   } mdl_t;

   mdl_t ma, mb;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ref_pix(input logic [1:0] md, input logic [11:0] lv,
                                           input int x, input int y, input int ha);
      case (md)
         2'd0:    return lv;
         2'd1:    return 12'((x / 2) * 4);
         2'd2:    return (x < ha / 2) ? 12'd0 : lv;
         default: return (((x / 16) % 2) != ((y / 16) % 2)) ? lv : 12'd0;
      endcase
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.run = 0; m.slot = 0; m.mode = '0; m.level = '0; m.frames = '0;
      m.data = '0; m.x = '0; m.y = '0; m.dval = 0; m.done = 0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int ha, input int va, input int hb,
                                     input int vb, input bit en, input bit st, input bit ct,
                                     input logic [1:0] md, input logic [11:0] lv);
      mdl_t n;
      int   line, col;
      n = m;
      n.dval = 0;
      n.done = 0;
      if (!en) return n;
      if (!n.run) begin
         if (st) begin
            n.run = 1; n.slot = 0; n.mode = md; n.level = lv;
         end
      end else begin
         line = n.slot / (ha + hb);
         col  = n.slot % (ha + hb);
         if (line < va && col < ha) begin
            n.data = ref_pix(n.mode, n.level, col, line, ha);
            n.x    = 11'(col);
            n.y    = 11'(line);
            n.dval = 1;
         end
         n.slot++;
         if (n.slot == (va + vb) * (ha + hb)) begin
            n.done   = 1;
            n.frames = n.frames + 16'd1;
            if (ct) begin
               n.slot = 0; n.mode = md; n.level = lv;
            end else begin
               n.run = 0;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [63:0] exp_outs(input mdl_t m);
      return 64'({m.data, m.dval, m.x, m.y, m.run, m.done, m.frames});
   endfunction

   function automatic logic [63:0] outs_a();
      return 64'({bus_a.oDATA, bus_a.oDVAL, bus_a.oX_Cont, bus_a.oY_Cont, a_busy, a_done, a_fcnt});
   endfunction

   function automatic logic [63:0] outs_b();
      return 64'({bus_b.oDATA, bus_b.oDVAL, bus_b.oX_Cont, bus_b.oY_Cont, b_busy, b_done, b_fcnt});
   endfunction

   // One clock: advance both models with the inputs the DUTs sampled, then compare.
   task automatic cycle();
      @(posedge iCLK);
      if (!iRST) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = mdl_step(ma, HA, VA, HB, VB, iPIX_EN, iSTART, iCONT, iMODE, iLEVEL);
         mb = mdl_step(mb, HA2, VA2, HB2, VB2, iPIX_EN, iSTART, iCONT, iMODE, iLEVEL);
      end
      #1;
      check("A_outs", outs_a(), exp_outs(ma));
      check("B_outs", outs_b(), exp_outs(mb));
   endtask

   task automatic do_reset();
      iRST = 1'b0;
      cycle();
      cycle();
      iRST = 1'b1;
   endtask

   task automatic start_frame(input logic [1:0] md, input logic [11:0] lv);
      iMODE = md; iLEVEL = lv; iPIX_EN = 1'b1; iSTART = 1'b1;
      cycle();
      iSTART = 1'b0;
   endtask

   int          cnt, bad, bad2, dn, done_at, last0, first1, ydec, found, f2k, gap_ok, chk_next;
   int          stall_dv, px2, b_lvl;
   bit          en_now;
   logic [10:0] prev_y;
   logic [33:0] q_ref[$];
   logic [33:0] q_st[$];
   logic [11:0] img[4][8];
   logic [11:0] row_d[8];
   logic [10:0] row_x[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      ma = mdl_reset();
      mb = mdl_reset();

      // Reset state
      repeat (3) cycle();
      check("reset_outs", outs_a(), 64'd0);
      iRST = 1'b1;
      cycle();

      // Flat frame
      start_frame(2'd0, 12'h123);
      cnt = 0; bad = 0; dn = 0; done_at = -1;
      for (int k = 1; k <= 60; k++) begin
         cycle();
         if (bus_a.oDVAL) begin
            cnt++;
            if (bus_a.oDATA !== 12'h123) bad++;
         end
         if (a_done) begin
            dn++;
            if (done_at < 0) done_at = k;
         end
      end
      check("flat_dval_cnt", 64'(cnt), 64'd32);
      check("flat_data", 64'(bad), 64'd0);
      check("flat_done_slot", 64'(done_at), 64'd50);
      check("flat_done_once", 64'(dn), 64'd1);
      check("flat_fcnt", 64'(a_fcnt), 64'd1);
      check("flat_busy_after", 64'(a_busy), 64'd0);

      // Ramp and coordinates
      start_frame(2'd1, 12'h555);
      cnt = 0; last0 = -1; first1 = -1; ydec = 0; prev_y = '0;
      q_ref.delete();
      for (int k = 1; k <= 52; k++) begin
         cycle();
         if (bus_a.oDVAL) begin
            q_ref.push_back({bus_a.oX_Cont, bus_a.oY_Cont, bus_a.oDATA});
            if (bus_a.oY_Cont < prev_y) ydec++;
            prev_y = bus_a.oY_Cont;
            if (bus_a.oY_Cont == 11'd0 && cnt < 8) begin
               row_x[cnt] = bus_a.oX_Cont;
               row_d[cnt] = bus_a.oDATA;
               cnt++;
               last0 = k;
            end
            if (bus_a.oY_Cont == 11'd1 && first1 < 0) first1 = k;
         end
      end
      check("ramp_row0_len", 64'(cnt), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check("ramp_x", 64'(row_x[i]), 64'(i));
         check("ramp_data", 64'(row_d[i]), 64'((i / 2) * 4));
      end
      check("ramp_line_gap", 64'(first1 - last0 - 1), 64'd2);
      check("ramp_y_order", 64'(ydec), 64'd0);
      check("ramp_last_y", 64'(prev_y), 64'd3);
      check("ramp_px_cnt", 64'(q_ref.size()), 64'd32);

      // Bar with edge, cell uniformity
      start_frame(2'd2, 12'hFFF);
      cnt = 0; bad = 0; bad2 = 0;
      for (int k = 1; k <= 52; k++) begin
         cycle();
         if (bus_a.oDVAL && bus_a.oX_Cont < 11'd8 && bus_a.oY_Cont < 11'd4) begin
            img[bus_a.oY_Cont][bus_a.oX_Cont] = bus_a.oDATA;
            cnt++;
            if (bus_a.oDATA !== ((bus_a.oX_Cont < 11'd4) ? 12'h000 : 12'hFFF)) bad++;
         end
      end
      for (int cy = 0; cy < 2; cy++)
         for (int cx = 0; cx < 4; cx++)
            if (img[2*cy][2*cx] !== img[2*cy][2*cx+1] || img[2*cy][2*cx] !== img[2*cy+1][2*cx] ||
                img[2*cy][2*cx] !== img[2*cy+1][2*cx+1]) bad2++;
      check("bar_px_cnt", 64'(cnt), 64'd32);
      check("bar_data", 64'(bad), 64'd0);
      check("bar_cell_uniform", 64'(bad2), 64'd0);

      // Stall handling: random iPIX_EN must not change the pixel sequence
      start_frame(2'd1, 12'h555);
      q_st.delete();
      stall_dv = 0; found = 0; cnt = 0;
      while (!found && cnt < 400) begin
         cnt++;
         iPIX_EN = 1'($urandom_range(0, 1));
         en_now = iPIX_EN;
         cycle();
         if (!en_now && bus_a.oDVAL) stall_dv++;
         if (bus_a.oDVAL) q_st.push_back({bus_a.oX_Cont, bus_a.oY_Cont, bus_a.oDATA});
         if (a_done) found = 1;
      end
      iPIX_EN = 1'b1;
      bad = 0;
      for (int i = 0; i < q_st.size() && i < q_ref.size(); i++)
         if (q_st[i] !== q_ref[i]) bad++;
      check("stall_done_seen", 64'(found), 64'd1);
      check("stall_seq_len", 64'(q_st.size()), 64'd32);
      check("stall_seq", 64'(bad), 64'd0);
      check("stall_dval_low", 64'(stall_dv), 64'd0);

      // Reset mid-line at pixel (3,1)
      start_frame(2'd0, 12'h321);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle();
         if (bus_a.oDVAL && bus_a.oX_Cont == 11'd3 && bus_a.oY_Cont == 11'd1) found = 1;
      end
      check("rst_reach_3_1", 64'(found), 64'd1);
      #2 iRST = 1'b0;
      #1;
      ma = mdl_reset();
      mb = mdl_reset();
      check("rst_mid_outs_a", outs_a(), 64'd0);
      check("rst_mid_outs_b", outs_b(), 64'd0);
      cycle();
      cycle();
      iRST = 1'b1;
      start_frame(2'd0, 12'h321);
      cycle();
      check("restart_origin", 64'({bus_a.oDVAL, bus_a.oX_Cont, bus_a.oY_Cont}), 64'({1'b1, 22'd0}));
      repeat (52) cycle();
      check("restart_fcnt", 64'(a_fcnt), 64'd1);

      // Continuous mode with mid-frame mode change and iCONT drop
      do_reset();
      iCONT = 1'b1;
      start_frame(2'd0, 12'h0F0);
      dn = 0; cnt = 0; bad = 0; bad2 = 0; f2k = 0; gap_ok = 0; chk_next = 0; px2 = 0;
      while (dn < 2 && cnt < 300) begin
         cnt++;
         if (dn == 0 && cnt == 20) iMODE = 2'd3;
         if (dn == 1) begin
            f2k++;
            if (f2k == 20) iCONT = 1'b0;
         end
         cycle();
         if (chk_next) begin
            gap_ok = (bus_a.oDVAL && bus_a.oX_Cont == 11'd0 && bus_a.oY_Cont == 11'd0) ? 1 : 0;
            chk_next = 0;
         end
         if (bus_a.oDVAL) begin
            if (dn == 0 && bus_a.oDATA !== 12'h0F0) bad++;
            if (dn == 1) begin
               px2++;
               if (bus_a.oDATA !== 12'h000) bad2++;
            end
         end
         if (a_done) begin
            dn++;
            if (dn == 1) chk_next = 1;
         end
      end
      cnt = 0;
      repeat (6) begin
         cycle();
         if (bus_a.oDVAL) cnt++;
      end
      check("cont_frames_seen", 64'(dn), 64'd2);
      check("cont_f1_flat", 64'(bad), 64'd0);
      check("cont_f2_checker", 64'(bad2), 64'd0);
      check("cont_f2_px", 64'(px2), 64'd32);
      check("cont_no_gap", 64'(gap_ok), 64'd1);
      check("cont_fcnt", 64'(a_fcnt), 64'd2);
      check("cont_idle_busy", 64'(a_busy), 64'd0);
      check("cont_idle_dval", 64'(cnt), 64'd0);

      // Wider geometry: checker with both x[4] and y[4] exercised, no vertical blanking
      cnt = 0;
      while (b_busy && cnt < 1000) begin
         cnt++;
         cycle();
      end
      check("b_idle_wait", 64'(b_busy), 64'd0);
      start_frame(2'd3, 12'hABC);
      cnt = 0; b_lvl = 0; done_at = -1;
      for (int k = 1; k <= 850; k++) begin
         cycle();
         if (bus_b.oDVAL) begin
            cnt++;
            if (bus_b.oDATA == 12'hABC) b_lvl++;
         end
         if (b_done && done_at < 0) done_at = k;
      end
      check("b_px_cnt", 64'(cnt), 64'd800);
      check("b_checker_lvl", 64'(b_lvl), 64'd352);
      check("b_done_slot", 64'(done_at), 64'd840);

      // Random soak against the model
      for (int k = 0; k < 2000; k++) begin
         iPIX_EN = ($urandom_range(0, 3) != 0);
         iSTART  = ($urandom_range(0, 7) == 0);
         iCONT   = ($urandom_range(0, 2) == 0);
         iMODE   = 2'($urandom);
         iLEVEL  = 12'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
